multicycle_control: RTL

Multi-cycle successor to the single-cycle CPU control decoder. It sequences each MIPS instruction through FETCH, DECODE, EXEC, MEM and WB states, and handshakes with a variable-latency memory. It decodes a wider instruction subset, latches the instruction fields, and adds a sticky halt with fault reporting. It sits between the instruction register and the datapath muxes, register file, ALU and memory port.

---
 rtl/cpu_ctrl_pkg.sv | 64 ++++++
 rtl/alu_op_decoder.sv | 42 ++++
 rtl/multicycle_control.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit.
// The MULDIV state only exists when MULDIV_EN is defined.
package cpu_ctrl_pkg;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnSll     = 6'b000000;
  localparam logic [5:0] FnSrl     = 6'b000010;
  localparam logic [5:0] FnJr      = 6'b001000;
  localparam logic [5:0] FnSyscall = 6'b001100;
  localparam logic [5:0] FnMult    = 6'b011000;
  localparam logic [5:0] FnDiv     = 6'b011010;
  localparam logic [5:0] FnAdd     = 6'b100000;
  localparam logic [5:0] FnAddu    = 6'b100001;
  localparam logic [5:0] FnSub     = 6'b100010;
  localparam logic [5:0] FnAnd     = 6'b100100;
  localparam logic [5:0] FnOr      = 6'b100101;
  localparam logic [5:0] FnSlt     = 6'b101010;

  typedef enum logic [3:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluAnd = 4'd2,
    AluOr  = 4'd3,
    AluSlt = 4'd4,
    AluSll = 4'd5,
    AluSrl = 4'd6,
    AluLui = 4'd7,
    AluMul = 4'd8,
    AluDiv = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
`ifdef MULDIV_EN
    StMulDiv = 3'd4,
`endif
    StMem    = 3'd5,
    StWb     = 3'd6,
    StHalt   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    PcPlus4  = 2'b00,
    PcBranch = 2'b01,
    PcJump   = 2'b10,
    PcReg    = 2'b11
  } pc_src_e;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational opcode/func to ALU operation map with a supported flag.
// MULT/DIV decode only when MULDIV_EN is defined.
module alu_op_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] func_i,
  output alu_op_e    alu_op_o,
  output logic       supported_o
);

  always_comb begin
    alu_op_o    = AluAdd;
    supported_o = 1'b1;
    if (opcode_i == OpRType) begin
      case (func_i)
        FnAdd, FnAddu, FnJr, FnSyscall: alu_op_o = AluAdd;
        FnSub:                          alu_op_o = AluSub;
        FnAnd:                          alu_op_o = AluAnd;
        FnOr:                           alu_op_o = AluOr;
        FnSlt:                          alu_op_o = AluSlt;
        FnSll:                          alu_op_o = AluSll;
        FnSrl:                          alu_op_o = AluSrl;
`ifdef MULDIV_EN
        FnMult:                         alu_op_o = AluMul;
        FnDiv:                          alu_op_o = AluDiv;
`endif
        default:                        supported_o = 1'b0;
      endcase
    end else begin
      case (opcode_i)
        OpAddi, OpAddiu, OpLw, OpSw, OpJ, OpJal: alu_op_o = AluAdd;
        OpBeq, OpBne:                            alu_op_o = AluSub;
        OpAndi:                                  alu_op_o = AluAnd;
        OpOri:                                   alu_op_o = AluOr;
        OpLui:                                   alu_op_o = AluLui;
        default:                                 supported_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory handshake, timeout and sticky halt.
// Define MULDIV_EN to add the MULT/DIV occupancy state (MULDIV_CYCLES).
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT   = 16
`ifdef MULDIV_EN
  ,
  parameter int unsigned MULDIV_CYCLES = 8
`endif
) (
  input  logic       clk_i,
  input  logic       rst_b_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] func_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       alu_src_o,
  output logic       reg_dest_o,
  output logic       link_o,
  output logic       mem_or_reg_o,
  output logic       reg_write_enable_o,
  output logic       does_shift_amount_need_o,
  output logic [3:0] alu_operation_o,
  output logic       halted_o,
  output logic       illegal_op_o,
  output logic       mem_fault_o
);

  localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e        state_q, state_d;
  logic [5:0]    op_q, op_d, fn_q, fn_d;
  alu_op_e       alu_op_q, alu_op_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          halted_q, halted_d, illegal_q, illegal_d, fault_q, fault_d;

  alu_op_e dec_alu_op;
  logic    dec_supported;
  alu_op_e alu_op;
  pc_src_e pc_src;
  logic    timeout_hit;
  logic    is_r, is_lw, is_sw, is_branch, is_jr, use_imm;

  // Decoded from the live inputs but only consumed in DECODE, then latched.
  alu_op_decoder u_alu_op_decoder (
    .opcode_i    (opcode_i),
    .func_i      (func_i),
    .alu_op_o    (dec_alu_op),
    .supported_o (dec_supported)
  );

  assign is_r      = (op_q == OpRType);
  assign is_lw     = (op_q == OpLw);
  assign is_sw     = (op_q == OpSw);
  assign is_branch = (op_q == OpBeq) || (op_q == OpBne);
  assign is_jr     = is_r && (fn_q == FnJr);
  assign use_imm   = (op_q == OpAddi) || (op_q == OpAddiu) || (op_q == OpAndi) ||
                     (op_q == OpOri) || (op_q == OpLui) || is_lw || is_sw;

  // The waiting cycle that sees mem_ready still completes normally.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (to_cnt_q == TW'(MEM_TIMEOUT - 1));

`ifdef MULDIV_EN
  localparam int unsigned MW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  logic [MW-1:0] md_cnt_q, md_cnt_d;
  logic          md_last;

  assign md_last = (md_cnt_q == MW'(MULDIV_CYCLES - 1));

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (state_q == StMulDiv) md_cnt_d = md_last ? '0 : md_cnt_q + MW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) md_cnt_q <= '0;
    else          md_cnt_q <= md_cnt_d;
  end
`endif

  always_comb begin
    state_d                  = state_q;
    op_d                     = op_q;
    fn_d                     = fn_q;
    alu_op_d                 = alu_op_q;
    illegal_d                = illegal_q;
    fault_d                  = fault_q;
    mem_req_o                = 1'b0;
    mem_write_o              = 1'b0;
    ir_write_o               = 1'b0;
    pc_write_o               = 1'b0;
    pc_src                   = PcPlus4;
    alu_src_o                = 1'b0;
    reg_dest_o               = 1'b0;
    link_o                   = 1'b0;
    mem_or_reg_o             = 1'b0;
    reg_write_enable_o       = 1'b0;
    does_shift_amount_need_o = 1'b0;
    alu_op                   = AluAdd;

    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = StDecode;
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          state_d = StHalt;
        end
      end
      StDecode: begin
        op_d     = opcode_i;
        fn_d     = func_i;
        alu_op_d = dec_alu_op;
        if (!dec_supported) begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end else if (opcode_i == OpRType && func_i == FnSyscall) begin
          state_d = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        alu_op                   = alu_op_q;
        alu_src_o                = use_imm;
        does_shift_amount_need_o = is_r && (fn_q == FnSll || fn_q == FnSrl);
        if (is_branch) begin
          pc_write_o = (op_q == OpBeq) ? zero_i : !zero_i;
          pc_src     = PcBranch;
          state_d    = StFetch;
        end else if (op_q == OpJ) begin
          pc_write_o = 1'b1;
          pc_src     = PcJump;
          state_d    = StFetch;
        end else if (op_q == OpJal) begin
          pc_write_o = 1'b1;
          pc_src     = PcJump;
          state_d    = StWb;
        end else if (is_jr) begin
          pc_write_o = 1'b1;
          pc_src     = PcReg;
          state_d    = StFetch;
        end else if (is_lw || is_sw) begin
          state_d = StMem;
`ifdef MULDIV_EN
        end else if (is_r && (fn_q == FnMult || fn_q == FnDiv)) begin
          state_d = StMulDiv;
`endif
        end else begin
          state_d = StWb;
        end
      end
`ifdef MULDIV_EN
      StMulDiv: begin
        alu_op = alu_op_q;
        if (md_last) state_d = StWb;
      end
`endif
      StMem: begin
        mem_req_o   = 1'b1;
        mem_write_o = is_sw;
        if (mem_ready_i) begin
          state_d = is_lw ? StWb : StFetch;
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          state_d = StHalt;
        end
      end
      StWb: begin
        reg_write_enable_o = 1'b1;
        mem_or_reg_o       = is_lw;
        reg_dest_o         = is_r;
        link_o             = (op_q == OpJal);
        state_d            = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StHalt;
    endcase

    halted_d = halted_q | (state_d == StHalt);
  end

  // Counter restarts on every state change, so it only counts waits in FETCH/MEM.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_d != state_q) begin
      to_cnt_d = '0;
    end else if (state_q == StFetch || state_q == StMem) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      state_q   <= StIdle;
      op_q      <= '0;
      fn_q      <= '0;
      alu_op_q  <= AluAdd;
      to_cnt_q  <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      fn_q      <= fn_d;
      alu_op_q  <= alu_op_d;
      to_cnt_q  <= to_cnt_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
    end
  end

  assign pc_src_o        = pc_src;
  assign alu_operation_o = alu_op;
  assign halted_o        = halted_q;
  assign illegal_op_o    = illegal_q;
  assign mem_fault_o     = fault_q;

endmodule
